reset_sequencer: RTL and testbench

Multi-channel reset controller for the SoC core. It generalises the single-output reset conditioner: one asynchronous active-low board/system reset drives `CHANNELS` active-high reset outputs. Every output asserts immediately when the input reset asserts. On release, the reset is synchronised, then the channels are released one at a time in index order with a fixed cycle gap. After the sequence completes, software can pulse-reset a single channel or restart the whole sequence without touching the input reset.

---
 rtl/reset_sequencer.sv | 165 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: synchronises release of the board reset, frees the
// channels one by one with a fixed gap, then offers per-channel pulses and full restarts.
module reset_sequencer #(
    parameter int STAGES      = 4,
    parameter int CHANNELS    = 4,
    parameter int RELEASE_GAP = 8,
    parameter int SOFT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] soft_req,
    input  logic                restart_req,
    output logic [CHANNELS-1:0] rst_out,
    output logic                done
);

    localparam int GW = $clog2(RELEASE_GAP + 1);
    localparam int SW = $clog2(SOFT_CYCLES + 1);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [GW-1:0] GAP_LOAD = GW'(RELEASE_GAP - 1);
    localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [SW-1:0] SOFT_LOAD = SW'(SOFT_CYCLES);
    localparam logic [SW-1:0] SOFT_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0] SOFT_ONE  = SW'(1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE_SYNC = 2'd0,
        SEQ       = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [STAGES-1:0]   sync_r;
    logic                sync_ok_s;
    logic [GW-1:0]       gap_r, gap_s;
    logic [IW-1:0]       idx_r, idx_s;
    logic [SW-1:0]       soft_cnt_r [CHANNELS];
    logic [SW-1:0]       soft_cnt_s [CHANNELS];
    logic [CHANNELS-1:0] rst_out_r, rst_out_s;
    logic                done_r, done_s;
    logic                seq_step_s;

    assign sync_ok_s = sync_r[STAGES-1];
    assign rst_out   = rst_out_r;
    assign done      = done_r;

    // Release synchroniser: shifts ones in once rst_n is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], 1'b1};
        end
    end

    // Next-state, release sequencing and soft-pulse logic.
    always_comb begin
        state_s    = state_r;
        gap_s      = gap_r;
        idx_s      = idx_r;
        rst_out_s  = rst_out_r;
        done_s     = 1'b0;
        soft_cnt_s = soft_cnt_r;
        // The edge that sees sync_ok already releases channel 0, so IDLE_SYNC
        // performs the first SEQ step itself (index and gap are zero there).
        seq_step_s = (state_r == SEQ) || ((state_r == IDLE_SYNC) && sync_ok_s);

        case (state_r)
            IDLE_SYNC, SEQ: begin
                if (seq_step_s) begin
                    if (gap_r == GAP_ZERO) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            if (idx_r == IW'(c)) begin
                                rst_out_s[c] = 1'b0;
                            end else begin
                                rst_out_s[c] = rst_out_r[c];
                            end
                        end
                        if (idx_r == IDX_LAST) begin
                            state_s = RUN;
                            done_s  = 1'b1;
                        end else begin
                            state_s = SEQ;
                            idx_s   = idx_r + IDX_ONE;
                            gap_s   = GAP_LOAD;
                        end
                    end else begin
                        state_s = SEQ;
                        gap_s   = gap_r - GAP_ONE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (restart_req) begin
                    state_s   = SEQ;
                    idx_s     = IDX_ZERO;
                    gap_s     = GAP_ZERO;
                    rst_out_s = {CHANNELS{1'b1}};
                    done_s    = 1'b0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        soft_cnt_s[c] = SOFT_ZERO;
                    end
                end else begin
                    done_s = 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (soft_req[c]) begin
                            soft_cnt_s[c] = SOFT_LOAD;
                            rst_out_s[c]  = 1'b1;
                        end else if (soft_cnt_r[c] != SOFT_ZERO) begin
                            soft_cnt_s[c] = soft_cnt_r[c] - SOFT_ONE;
                            if (soft_cnt_r[c] == SOFT_ONE) begin
                                rst_out_s[c] = 1'b0;
                            end else begin
                                rst_out_s[c] = rst_out_r[c];
                            end
                        end else begin
                            soft_cnt_s[c] = soft_cnt_r[c];
                        end
                    end
                end
            end
            default: begin
                state_s   = IDLE_SYNC;
                idx_s     = IDX_ZERO;
                gap_s     = GAP_ZERO;
                rst_out_s = {CHANNELS{1'b1}};
                done_s    = 1'b0;
                for (int c = 0; c < CHANNELS; c++) begin
                    soft_cnt_s[c] = SOFT_ZERO;
                end
            end
        endcase
    end

    // State and output registers; rst_n forces outputs asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE_SYNC;
            gap_r     <= GAP_ZERO;
            idx_r     <= IDX_ZERO;
            rst_out_r <= {CHANNELS{1'b1}};
            done_r    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                soft_cnt_r[c] <= SOFT_ZERO;
            end
        end else begin
            state_r   <= state_s;
            gap_r     <= gap_s;
            idx_r     <= idx_s;
            rst_out_r <= rst_out_s;
            done_r    <= done_s;
            for (int c = 0; c < CHANNELS; c++) begin
                soft_cnt_r[c] <= soft_cnt_s[c];
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a
// CHANNELS=1 / RELEASE_GAP=1 / STAGES=2 corner instance sharing clock and reset.
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] soft_req;
    logic       restart_req;
    logic [3:0] rst_out;
    logic       done;
    logic [0:0] corner_rst;
    logic       corner_done;
    logic [0:0] corner_soft;
    logic       corner_restart;

    int total_cnt;
    int bad_cnt;

    reset_sequencer #(
        .STAGES(4), .CHANNELS(4), .RELEASE_GAP(8), .SOFT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .soft_req(soft_req),
        .restart_req(restart_req), .rst_out(rst_out), .done(done)
    );

    reset_sequencer #(
        .STAGES(2), .CHANNELS(1), .RELEASE_GAP(1), .SOFT_CYCLES(16)
    ) dut_corner (
        .clk(clk), .rst_n(rst_n), .soft_req(corner_soft),
        .restart_req(corner_restart), .rst_out(corner_rst), .done(corner_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Channel k is released on edge first + 8*k counted from the sequence origin.
    function automatic logic [3:0] exp_rst(input int j, input int first);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) begin
            v[k] = (j < first + 8 * k) ? 1'b1 : 1'b0;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with rst_n low; releases it and checks edges 1..29.
    task automatic power_on(input string tag);
        rst_n = 1'b1;
        for (int e = 1; e <= 29; e++) begin
            step();
            check_val({tag, "_rst"}, 32'(rst_out), 32'(exp_rst(e, 5)));
            check_val({tag, "_done"}, 32'(done), 32'(e >= 29));
            check_val({tag, "_c_rst"}, 32'(corner_rst), 32'(e < 3));
            check_val({tag, "_c_done"}, 32'(corner_done), 32'(e >= 3));
        end
    endtask

    initial begin
        total_cnt      = 0;
        bad_cnt        = 0;
        rst_n          = 1'b0;
        soft_req       = 4'b0000;
        restart_req    = 1'b0;
        corner_soft    = 1'b0;
        corner_restart = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_val("reset_rst", 32'(rst_out), 32'h0000_000F);
        check_val("reset_done", 32'(done), 32'h0000_0000);
        check_val("reset_c_rst", 32'(corner_rst), 32'h0000_0001);
        power_on("por");

        // Asynchronous assertion between edges while in RUN.
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst", 32'(rst_out), 32'h0000_000F);
        check_val("async_done", 32'(done), 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        power_on("por2");

        // Single soft pulse on channel 2.
        soft_req = 4'b0100;
        step();
        soft_req = 4'b0000;
        check_val("soft_req_edge", 32'(rst_out), 32'h0000_0004);
        for (int j = 1; j <= 17; j++) begin
            step();
            check_val("soft_pulse", 32'(rst_out), (j <= 15) ? 32'h0000_0004 : 32'h0000_0000);
            check_val("soft_done", 32'(done), 32'h0000_0001);
        end

        // Retrigger five edges after the first request.
        soft_req = 4'b0100;
        step();
        soft_req = 4'b0000;
        for (int j = 1; j <= 4; j++) begin
            step();
            check_val("retrig_first", 32'(rst_out), 32'h0000_0004);
        end
        soft_req = 4'b0100;
        step();
        soft_req = 4'b0000;
        check_val("retrig_edge", 32'(rst_out), 32'h0000_0004);
        for (int j = 6; j <= 22; j++) begin
            step();
            check_val("retrig_pulse", 32'(rst_out), (j <= 20) ? 32'h0000_0004 : 32'h0000_0000);
        end

        // Restart with a simultaneous soft request: restart wins.
        restart_req = 1'b1;
        soft_req    = 4'b0001;
        step();
        restart_req = 1'b0;
        soft_req    = 4'b0000;
        check_val("restart_rst", 32'(rst_out), 32'h0000_000F);
        check_val("restart_done", 32'(done), 32'h0000_0000);
        for (int j = 1; j <= 30; j++) begin
            step();
            check_val("restart_seq", 32'(rst_out), 32'(exp_rst(j, 1)));
            check_val("restart_seq_done", 32'(done), 32'(j >= 25));
        end

        // Requests during SEQ are ignored; then abort with two channels released.
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        check_val("seq2_start", 32'(rst_out), 32'h0000_000F);
        for (int j = 1; j <= 10; j++) begin
            if (j == 3) begin
                soft_req    = 4'b1111;
                restart_req = 1'b1;
            end
            step();
            soft_req    = 4'b0000;
            restart_req = 1'b0;
            check_val("seq_ignore", 32'(rst_out), 32'(exp_rst(j, 1)));
            check_val("seq_ignore_done", 32'(done), 32'h0000_0000);
        end
        check_val("pre_abort", 32'(rst_out), 32'h0000_000C);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_rst", 32'(rst_out), 32'h0000_000F);
        check_val("abort_done", 32'(done), 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        power_on("por3");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
